t_trig_array: RTL and testbench
===============================

T_TRIG_ARRAY -- requirements
Module: t_trig_array

Interface
REQ-001 Parameter WIDTH, default 8: number of toggle cells (1..32).
REQ-002 Parameter RST_VAL, default 0: WIDTH-bit reset value of the cell register.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_mode  input  2  00 level toggle, 01 edge toggle, 10 chained counter, 11 hold.
REQ-006 i_t  input  WIDTH  per-cell toggle request.
REQ-007 i_load  input  1  synchronous parallel load strobe.
REQ-008 i_din  input  WIDTH  parallel load data.
REQ-009 o_q  output  WIDTH  cell register state.
REQ-010 o_qb  output  WIDTH  bitwise complement of o_q.
REQ-011 o_wrap  output  1  registered one-cycle pulse on counter wrap.

Function
REQ-012 State SHALL be the WIDTH-bit register r_q, the WIDTH-bit input history r_t_d, and the 1-bit register r_wrap; o_q = r_q, o_wrap = r_wrap.
REQ-013 o_qb SHALL equal ~r_q combinationally in every cycle, including during reset.
REQ-014 Per-edge priority SHALL be: i_load, then the i_mode action.
REQ-015 i_load=1: r_q <= i_din regardless of i_mode and i_t; r_wrap <= 0.
REQ-016 Mode 00 (level): r_q <= r_q ^ i_t; each cell toggles on every edge at which its i_t bit is 1.
REQ-017 Mode 01 (edge): r_q <= r_q ^ (i_t & ~r_t_d); each cell toggles once per 0->1 transition of its i_t bit; a held-high i_t SHALL NOT toggle again.
REQ-018 r_t_d SHALL sample i_t on every edge, in all modes and during load, so that entering mode 01 with i_t already high does not toggle.
REQ-019 Mode 10 (counter): cell k toggles when i_t[0]=1 and r_q[k-1:0] are all 1 (cell 0 toggles when i_t[0]=1); net effect r_q <= r_q + 1 modulo 2^WIDTH; i_t[WIDTH-1:1] is ignored.
REQ-020 Mode 10 wrap: when i_t[0]=1, i_load=0, and r_q is all ones, r_q <= 0 and r_wrap <= 1 for exactly that next cycle.
REQ-021 r_wrap SHALL be 0 in every cycle not covered by REQ-020, including all cycles in modes 00, 01, and 11.
REQ-022 Mode 11 (hold): r_q <= r_q; i_t is ignored except by REQ-018.
REQ-023 Mode changes SHALL take effect on the same edge at which the new i_mode is sampled; no pipeline latency; results appear on o_q one edge after the request.

Reset
REQ-024 i_rst_n=0 SHALL immediately, without a clock, force r_q=RST_VAL, r_t_d=0, and r_wrap=0, so that o_q=RST_VAL, o_qb=~RST_VAL, and o_wrap=0.
REQ-025 Reset asserted mid-operation SHALL abort any count or toggle; the first edge with i_rst_n=1 applies normal rules from the reset state.
REQ-026 An edge coinciding with i_rst_n=0 SHALL have no effect.

Verification (WIDTH=8, RST_VAL=0)
REQ-027 Async reset: drive i_rst_n=0 between clock edges -> o_q=8'h00, o_qb=8'hFF, o_wrap=0 before the next edge.
REQ-028 Mode 00: from o_q=00, hold i_t=8'hA5 for 2 edges -> o_q=A5, then 00.
REQ-029 Mode 01: from o_q=00, hold i_t=8'h0F for 3 edges -> o_q=0F after the first edge and remains 0F; then drive i_t=00 for 1 edge and 0F for 1 edge -> o_q=00.
REQ-030 Mode 10: load i_din=8'hFE, then hold i_t[0]=1 for 3 edges -> o_q=FF with o_wrap=0; then o_q=00 with o_wrap=1; then o_q=01 with o_wrap=0.
REQ-031 Priority: in mode 00, apply i_load=1, i_din=8'h3C, i_t=8'hFF on one edge -> o_q=3C; in mode 10 at o_q=FF, apply i_load=1, i_din=8'h10 -> o_q=10 with o_wrap=0.
REQ-032 Hold and reset: in mode 11 with i_t=8'hFF for 4 edges -> o_q unchanged; then switch to mode 10 and count to 8'h05, assert i_rst_n=0 -> o_q=00 immediately, and counting resumes from 00 after release.

Source files
------------

// File: rtl/t_trig_array.sv
// Array of WIDTH toggle cells with level, edge, chained-counter and hold modes,
// a synchronous parallel load, and a registered wrap pulse in counter mode.
module t_trig_array #(
    parameter int unsigned             WIDTH   = 8,
    parameter logic [WIDTH-1:0]        RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_t,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qb,
    output logic             o_wrap
);

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_EDGE  = 2'b01,
        MODE_COUNT = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_t_d;
    logic             r_wrap;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_cnt_tgl;
    logic [WIDTH-1:0] w_tgl;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    mode_e            w_mode;

    assign w_mode = mode_e'(i_mode);
    assign w_rise = i_t & ~r_t_d;

    // Ripple toggle-enable chain: cell k toggles when all lower cells are 1.
    always_comb begin
        w_cnt_tgl    = {WIDTH{1'b0}};
        w_cnt_tgl[0] = i_t[0];
        for (int k = 1; k < int'(WIDTH); k++) begin
            w_cnt_tgl[k] = w_cnt_tgl[k-1] & r_q[k-1];
        end
    end

    // Per-cell toggle enables selected by the operating mode.
    always_comb begin
        w_tgl = {WIDTH{1'b0}};
        case (w_mode)
            MODE_LEVEL: w_tgl = i_t;
            MODE_EDGE:  w_tgl = w_rise;
            MODE_COUNT: w_tgl = w_cnt_tgl;
            MODE_HOLD:  w_tgl = {WIDTH{1'b0}};
            default:    w_tgl = {WIDTH{1'b0}};
        endcase
    end

    // Next state: load takes priority over any mode action.
    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        if (i_load) begin
            w_q_nxt    = i_din;
            w_wrap_nxt = 1'b0;
        end else begin
            w_q_nxt    = r_q ^ w_tgl;
            w_wrap_nxt = (w_mode == MODE_COUNT) && i_t[0] && (&r_q);
        end
    end

    // State registers; input history is sampled on every edge regardless of mode or load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q    <= RST_VAL;
            r_t_d  <= {WIDTH{1'b0}};
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_t_d  <= i_t;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign o_q    = r_q;
    assign o_qb   = ~r_q;
    assign o_wrap = r_wrap;

endmodule

// File: tb/tb_t_trig_array.sv
// Self-checking bench for t_trig_array: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_t_trig_array;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] t;
    logic       load;
    logic [7:0] din;
    logic [7:0] q;
    logic [7:0] qb;
    logic       wrap;

    int n_vec;
    int n_err;
    bit chk_on;

    logic [7:0] m_q;
    logic [7:0] m_prev;
    logic       m_wrap;

    t_trig_array #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_mode (mode),
        .i_t    (t),
        .i_load (load),
        .i_din  (din),
        .o_q    (q),
        .o_qb   (qb),
        .o_wrap (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: register value as a number, counter as +1 mod 256.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= 8'h00;
            m_prev <= 8'h00;
            m_wrap <= 1'b0;
        end else begin
            m_prev <= t;
            m_wrap <= 1'b0;
            if (load) begin
                m_q <= din;
            end else if (mode == 2'd0) begin
                m_q <= m_q ^ t;
            end else if (mode == 2'd1) begin
                m_q <= m_q ^ (t & ~m_prev);
            end else if (mode == 2'd2 && t[0]) begin
                m_q    <= 8'((int'(m_q) + 1) % 256);
                m_wrap <= (int'(m_q) == 255);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_q", {24'h0, q}, {24'h0, m_q});
            chk("model_qb", {24'h0, qb}, {24'h0, ~m_q});
            chk("model_wrap", {31'h0, wrap}, {31'h0, m_wrap});
        end
    end

    task automatic drive(input logic [1:0] m, input logic [7:0] tv, input logic ld, input logic [7:0] d);
        mode = m;
        t    = tv;
        load = ld;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expq(input string name, input logic [7:0] eq, input logic ew);
        chk(name, {24'h0, q}, {24'h0, eq});
        chk({name, "_wrap"}, {31'h0, wrap}, {31'h0, ew});
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        chk_on = 1'b0;
        rst_n  = 1'b0;
        mode   = 2'd0;
        t      = 8'h00;
        load   = 1'b0;
        din    = 8'h00;
        @(posedge clk);
        #1;
        expq("reset_q", 8'h00, 1'b0);
        chk("reset_qb", {24'h0, qb}, {24'h0, 8'hFF});
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Level toggle
        drive(2'd0, 8'hA5, 1'b0, 8'h00); expq("lvl1", 8'hA5, 1'b0);
        drive(2'd0, 8'hA5, 1'b0, 8'h00); expq("lvl2", 8'h00, 1'b0);
        drive(2'd3, 8'h00, 1'b0, 8'h00); expq("hold_clr", 8'h00, 1'b0);

        // Edge toggle
        drive(2'd1, 8'h0F, 1'b0, 8'h00); expq("edge1", 8'h0F, 1'b0);
        drive(2'd1, 8'h0F, 1'b0, 8'h00); expq("edge2", 8'h0F, 1'b0);
        drive(2'd1, 8'h0F, 1'b0, 8'h00); expq("edge3", 8'h0F, 1'b0);
        drive(2'd1, 8'h00, 1'b0, 8'h00); expq("edge_lo", 8'h0F, 1'b0);
        drive(2'd1, 8'h0F, 1'b0, 8'h00); expq("edge_re", 8'h00, 1'b0);

        // Counter with wrap
        drive(2'd2, 8'h00, 1'b1, 8'hFE); expq("ld_fe", 8'hFE, 1'b0);
        drive(2'd2, 8'h01, 1'b0, 8'h00); expq("cnt_ff", 8'hFF, 1'b0);
        drive(2'd2, 8'h01, 1'b0, 8'h00); expq("cnt_wrap", 8'h00, 1'b1);
        drive(2'd2, 8'h01, 1'b0, 8'h00); expq("cnt_01", 8'h01, 1'b0);

        // Load priority
        drive(2'd0, 8'hFF, 1'b1, 8'h3C); expq("pri_lvl", 8'h3C, 1'b0);
        drive(2'd2, 8'h00, 1'b1, 8'hFF); expq("ld_ff", 8'hFF, 1'b0);
        drive(2'd2, 8'h01, 1'b1, 8'h10); expq("pri_cnt", 8'h10, 1'b0);

        // Hold, then edge mode entered with i_t already high
        for (int i = 0; i < 4; i++) begin
            drive(2'd3, 8'hFF, 1'b0, 8'h00); expq("hold", 8'h10, 1'b0);
        end
        drive(2'd1, 8'hFF, 1'b0, 8'h00); expq("edge_held", 8'h10, 1'b0);

        // Count to 5, then async reset mid-count
        drive(2'd2, 8'h00, 1'b1, 8'h00); expq("ld_00", 8'h00, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            drive(2'd2, 8'h01, 1'b0, 8'h00); expq("cnt_up", 8'(i), 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        expq("async_rst", 8'h00, 1'b0);
        chk("async_rst_qb", {24'h0, qb}, {24'h0, 8'hFF});
        @(posedge clk);
        #1;
        expq("rst_edge", 8'h00, 1'b0);
        rst_n = 1'b1;
        drive(2'd2, 8'h01, 1'b0, 8'h00); expq("resume1", 8'h01, 1'b0);
        drive(2'd2, 8'h01, 1'b0, 8'h00); expq("resume2", 8'h02, 1'b0);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 3) == 0) begin
                mode = 2'd2;
                din  = 8'($urandom_range(250, 255));
            end else begin
                mode = 2'($urandom);
                din  = 8'($urandom);
            end
            t    = 8'($urandom);
            load = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
